// File: rtl/imm_extend_queue.sv
// imm_extend_queue: registered immediate extender feeding a DEPTH-entry valid/ready FIFO
module imm_extend_queue #(
  parameter int IN_W     = 27,
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 12,
  parameter int BR_SHIFT = 2,
  parameter int DEPTH    = 2,
  parameter int TAG_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              num_in,
  input  logic [1:0]                   imm_src,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            num_out,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] ext, zext8;
  logic [31:0]       rot_amt;
  logic              push, pop;
  assign in_ready  = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign num_out   = out_valid ? data_mem[rd_ptr] : '0;
  assign out_tag   = out_valid ? tag_mem[rd_ptr] : '0;
  // extend the immediate at push time; mode 11 is an 8-bit value rotated right by twice a 4-bit field
  always_comb begin
    zext8   = DATA_W'(num_in[7:0]);
    rot_amt = 32'({num_in[11:8], 1'b0}) % 32'(DATA_W);
    ext = imm_src == 2'b00 ? DATA_W'(num_in[IMM_W-1:0])
        : imm_src == 2'b01 ? {{(DATA_W-IMM_W){num_in[IMM_W-1]}}, num_in[IMM_W-1:0]}
        : imm_src == 2'b10 ? {{(DATA_W-IN_W){num_in[IN_W-1]}}, num_in} << BR_SHIFT
        : (zext8 >> rot_amt) | (zext8 << (32'(DATA_W) - rot_amt));
  end
  // storage carries no reset; flush suppresses the write so a dropped push leaves no trace
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= ext;
      tag_mem[wr_ptr]  <= in_tag;
    end
  end
  // pointers and occupancy; flush outranks push and pop, pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_imm_extend_queue.sv
// tb_imm_extend_queue: vector table, corner sequences and randomized model check of imm_extend_queue
module tb_imm_extend_queue;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [26:0] num_in = '0;
  logic [1:0]  imm_src = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [31:0] num_out;
  logic [3:0]  out_tag;
  logic [1:0]  count;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] data; logic [3:0] tag;} entry_t;
  typedef struct {logic [26:0] num; logic [1:0] src; logic [31:0] exp;} vec_t;
  entry_t model_q[$];
  vec_t   vecs[9];

  imm_extend_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .num_in(num_in), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .num_out(num_out), .out_tag(out_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_ext(input logic [26:0] n, input logic [1:0] m);
    longint v;
    int r;
    case (m)
      2'd0: v = n % 4096;
      2'd1: begin v = n % 4096; if (v >= 2048) v -= 4096; end
      2'd2: begin v = n; if (v >= (longint'(1) << 26)) v -= (longint'(1) << 27); v = v * 4; end
      default: begin v = n % 256; r = (2 * ((n / 256) % 16)) % 32; v = (v >> r) | (v << (32 - r)); end
    endcase
    return v[31:0];
  endfunction

  task automatic push_one(input logic [26:0] n, input logic [1:0] m, input logic [3:0] t);
    num_in = n; imm_src = m; in_tag = t; in_valid = 1;
    step;
    in_valid = 0; num_in = 27'($urandom); imm_src = 2'($urandom);
  endtask

  initial begin
    logic [26:0] n1, n2, nn;
    logic [1:0]  m1, m2;
    logic        p, q;
    vecs[0] = '{27'h0F3F0F0, 2'd0, 32'h000000F0};
    vecs[1] = '{27'h0F3F0F0, 2'd1, 32'h000000F0};
    vecs[2] = '{27'h0F3F0F0, 2'd2, 32'h03CFC3C0};
    vecs[3] = '{27'h0F3F0F0, 2'd3, 32'h000000F0};
    vecs[4] = '{27'h7FFFFFF, 2'd0, 32'h00000FFF};
    vecs[5] = '{27'h7FFFFFF, 2'd1, 32'hFFFFFFFF};
    vecs[6] = '{27'h7FFFFFF, 2'd2, 32'hFFFFFFFC};
    vecs[7] = '{27'h7FFFFFF, 2'd3, 32'h000003FC};
    vecs[8] = '{27'h00004FF, 2'd3, 32'hFF000000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst num_out", num_out, 0);
    chk("rst out_tag", 32'(out_tag), 0);
    chk("rst count", 32'(count), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      push_one(vecs[i].num, vecs[i].src, 4'(i));
      chk("vec out_valid", 32'(out_valid), 1);
      chk("vec num_out", num_out, vecs[i].exp);
      chk("vec out_tag", 32'(out_tag), 32'(i % 16));
      step;
      chk("vec drained", 32'(out_valid), 0);
    end
    out_ready = 0;
    n1 = 27'($urandom); m1 = 2'($urandom); n2 = 27'($urandom); m2 = 2'($urandom);
    push_one(n1, m1, 4'd1);
    push_one(n2, m2, 4'd2);
    chk("fill count", 32'(count), 2);
    chk("fill in_ready", 32'(in_ready), 0);
    num_in = 27'($urandom); in_tag = 4'd3; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("hold count", 32'(count), 2);
      chk("hold out_tag", 32'(out_tag), 1);
      chk("hold num_out", num_out, ref_ext(n1, m1));
    end
    in_valid = 0;
    out_ready = 1;
    step;
    chk("drain tag2", 32'(out_tag), 2);
    chk("drain num2", num_out, ref_ext(n2, m2));
    step;
    chk("drain empty", 32'(out_valid), 0);
    chk("drain num0", num_out, 0);
    for (int k = 0; k < 8; k++) begin
      nn = 27'($urandom);
      num_in = nn; imm_src = 2'(k); in_tag = 4'(k); in_valid = 1;
      step;
      chk("stream out_tag", 32'(out_tag), 32'(k));
      chk("stream count", 32'(count), 1);
      chk("stream num_out", num_out, ref_ext(nn, 2'(k)));
    end
    in_valid = 0;
    step;
    chk("stream end", 32'(out_valid), 0);
    out_ready = 0;
    push_one(27'h123, 2'd0, 4'd4);
    push_one(27'h456, 2'd0, 4'd5);
    flush = 1; in_valid = 1; in_tag = 4'd9;
    step;
    flush = 0; in_valid = 0;
    chk("flush count", 32'(count), 0);
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush in_ready", 32'(in_ready), 1);
    step;
    chk("flush no ghost", 32'(out_valid), 0);
    push_one(27'h789, 2'd0, 4'd6);
    flush = 1; in_valid = 1; in_tag = 4'd10; num_in = 27'h111;
    step;
    flush = 0; in_valid = 0;
    step;
    chk("flush drops push", 32'(out_valid), 0);
    push_one(27'h0AA, 2'd0, 4'd7);
    push_one(27'h0BB, 2'd0, 4'd8);
    chk("pre-reset count", 32'(count), 2);
    #3;
    rst_n = 0;
    #1;
    chk("async out_valid", 32'(out_valid), 0);
    chk("async num_out", num_out, 0);
    chk("async count", 32'(count), 0);
    chk("async out_tag", 32'(out_tag), 0);
    step;
    rst_n = 1;
    push_one(27'h0CC, 2'd0, 4'd11);
    chk("post-reset tag", 32'(out_tag), 11);
    chk("post-reset num", num_out, 32'h000000CC);
    out_ready = 1;
    step;
    chk("post-reset empty", 32'(out_valid), 0);
    model_q.delete();
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 20) == 0;
      num_in = 27'($urandom); imm_src = 2'($urandom); in_tag = 4'($urandom);
      chk("rnd out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("rnd count", 32'(count), 32'(model_q.size()));
      chk("rnd in_ready", 32'(in_ready), 32'(model_q.size() != 2));
      chk("rnd num_out", num_out, model_q.size() != 0 ? model_q[0].data : 32'h0);
      chk("rnd out_tag", 32'(out_tag), model_q.size() != 0 ? 32'(model_q[0].tag) : 32'h0);
      p = in_valid && model_q.size() != 2;
      q = out_ready && model_q.size() != 0;
      if (flush) model_q.delete();
      else begin
        if (q) void'(model_q.pop_front());
        if (p) model_q.push_back('{ref_ext(num_in, imm_src), in_tag});
      end
      step;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imm_extend_queue.md
Name: imm_extend_queue

Overview:
- Parametrised, registered successor to the decode-stage sign extender.
- Extends a packed instruction immediate field into a DATA_W-bit operand using one of four modes, including ARM-style rotated immediates.
- Holds results in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a pipeline flush, so decode can run ahead of or stall behind execute.
- Sits between the decode register and the execute-stage operand mux.

Parameters:
- IN_W, 27, width of num_in (packed immediate field).
- DATA_W, 32, width of the extended operand (>= IN_W+BR_SHIFT, >= 12).
- IMM_W, 12, field width for modes 00/01.
- BR_SHIFT, 2, left shift applied in mode 10 (branch offset to byte offset).
- DEPTH, 2, FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the sideband tag carried with each entry (destination register).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all queued entries (branch taken).
- in_valid  in  1  upstream offers num_in/imm_src/in_tag.
- in_ready  out  1  queue can accept this cycle.
- num_in  in  IN_W  raw immediate field.
- imm_src  in  2  extension mode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- num_out  out  DATA_W  extended operand at the head.
- out_tag  out  TAG_W  tag of the head entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Extension modes (combinational, evaluated at push time; the result is stored, not the raw field):
  - 00: zero-extend num_in[IMM_W-1:0].
  - 01: sign-extend num_in[IMM_W-1:0] from bit IMM_W-1.
  - 10: sign-extend all IN_W bits from bit IN_W-1, then shift left by BR_SHIFT, filling with zeros.
  - 11: zero-extend num_in[7:0] to DATA_W, then rotate right by 2*num_in[11:8] mod DATA_W. A rotate of 0 gives a plain zero-extend.
- Push: in_valid && in_ready at a rising edge.
- Pop: out_valid && out_ready at a rising edge.
- Latency: an entry pushed into an empty queue appears on out_valid/num_out in the next cycle. There is no combinational input-to-output path.
- Status signals:
  - in_ready = (count != DEPTH). It does not depend on out_ready, so a full queue does not accept even while it is popping.
  - out_valid = (count != 0).
  - num_out and out_tag are driven to 0 whenever out_valid = 0.
- Hold rule: while out_valid && !out_ready, num_out and out_tag stay stable, and the order of entries is preserved.
- Pointers: write and read pointers wrap modulo DEPTH.
- Simultaneous push and pop (0 < count < DEPTH): count is unchanged, both pointers advance, and the head updates to the next entry.
- flush:
  - Highest priority; it wins over push and pop in the same cycle.
  - Next cycle: count = 0, pointers = 0, out_valid = 0, in_ready = 1.
  - A push offered in the flush cycle is dropped.
  - A pop handshake in the flush cycle is still considered consumed by downstream.
- Reset (asynchronous assert, applies mid-operation too):
  - count = 0, pointers = 0, out_valid = 0, num_out = 0, out_tag = 0, in_ready = 1, storage contents don't-care.
  - The first push is accepted on the first rising edge after rst_n deasserts.
- imm_src and num_in are ignored when no push occurs. Unused high bits of num_in are ignored in modes 00, 01 and 11.

Test Plan:
- Mode sweep with defaults, num_in = 27'h0F3F0F0, one push per mode:
  - imm_src 00 -> 32'h000000F0
  - imm_src 01 -> 32'h000000F0
  - imm_src 10 -> 32'h03CFC3C0
  - imm_src 11 -> 32'h000000F0
  - Each result appears 1 cycle after its push.
- Negative and rotate cases:
  - num_in = 27'h7FFFFFF: 00 -> 32'h00000FFF; 01 -> 32'hFFFFFFFF; 10 -> 32'hFFFFFFFC; 11 -> 32'h000003FC.
  - num_in = 27'h00004FF, mode 11 -> 32'hFF000000.
- Fill and backpressure (out_ready = 0):
  - Push tags 1 and 2; count = 2, in_ready = 0, and a third in_valid is not accepted.
  - num_out/out_tag stay at tag 1 for 5 cycles.
  - Raise out_ready: entries emerge as tag 1 then tag 2, then out_valid = 0 and num_out = 0.
- Streaming: in_valid = out_ready = 1 for 8 cycles with tags 0..7:
  - out_tag sequence is 0..7 with no bubbles after the first cycle.
  - count stays at 1, and pointers wrap correctly.
- Flush with the queue full and a push offered in the same cycle: next cycle count = 0, out_valid = 0, in_ready = 1, and the offered entry never appears.
- Asynchronous reset asserted mid-stream with count = 2 and no clock edge: outputs go immediately to out_valid = 0, num_out = 0, count = 0. After release, the first push appears 1 cycle later.
